// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte sources, with burst lock.
// Optional WAIT watchdog enabled by defining UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          tx_dv,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic                          busy,
    output logic                          err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t                  state_reg;
    logic [NUM_REQ-1:0]      grant_reg;
    logic [NUM_REQ-1:0]      ack_reg;
    logic [PTR_W-1:0]        rr_ptr_reg;
    logic                    lock_reg;
    logic                    tx_dv_reg;
    logic [DATA_WIDTH-1:0]   tx_data_reg;

    logic [DATA_WIDTH-1:0]   req_byte [NUM_REQ];
    logic                    win_found;
    logic [PTR_W-1:0]        win_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_byte[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // rr_ptr holds the last winner, so scanning starts just after it.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = rr_ptr_reg;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[PTR_W-1:0];
            end
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             err_reg;
    assign err = err_reg;
`else
    // Without the watchdog err is a constant 0.
    assign err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (arst) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            ack_reg     <= '0;
            rr_ptr_reg  <= PTR_W'(NUM_REQ - 1);
            lock_reg    <= 1'b0;
            tx_dv_reg   <= 1'b0;
            tx_data_reg <= '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            tx_dv_reg <= 1'b0;
            ack_reg   <= '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            err_reg   <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        grant_reg  <= NUM_REQ'(1) << win_idx;
                        rr_ptr_reg <= win_idx;
                        state_reg  <= LOAD;
                    end
                end
                LOAD: begin
                    if (req[rr_ptr_reg]) begin
                        tx_dv_reg   <= 1'b1;
                        tx_data_reg <= req_byte[rr_ptr_reg];
                        ack_reg     <= grant_reg;
                        lock_reg    <= ~req_last[rr_ptr_reg];
                        state_reg   <= WAIT;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                    end else begin
                        grant_reg <= '0;
                        lock_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        if (lock_reg && req[rr_ptr_reg]) begin
                            state_reg <= LOAD;
                        end else begin
                            grant_reg <= '0;
                            lock_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                    else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_reg   <= 1'b1;
                        grant_reg <= '0;
                        lock_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ack     = ack_reg;
    assign grant   = grant_reg;
    assign tx_dv   = tx_dv_reg;
    assign tx_data = tx_data_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ independent byte sources using round-robin arbitration.
- Sequences the transmitter: issues a one-cycle start strobe, then waits for frame completion before re-arbitrating.
- Supports burst lock so one requester can send a multi-byte packet without interleaving.
- Sits between protocol/packet logic and the uart_tx instance in the transceiver top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width; must match uart_tx DATA_WIDTH
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only with optional feature)

Ports:
- clk  in  1  system clock
- arst  in  1  reset; synchronous, active-high
- req  in  NUM_REQ  per-requester request; held high until ack
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while req high
- req_last  in  NUM_REQ  1 = this byte ends the burst; 0 = keep lock
- ack  out  NUM_REQ  one-cycle pulse when requester's byte is handed to uart_tx
- grant  out  NUM_REQ  one-hot current owner; 0 when idle
- tx_dv  out  1  one-cycle start strobe to uart_tx
- tx_data  out  DATA_WIDTH  byte to uart_tx; valid with tx_dv, held until next load
- tx_done  in  1  one-cycle pulse from uart_tx at end of stop bit
- busy  out  1  high in any state other than IDLE
- err  out  1  watchdog abort pulse; constant 0 without feature

Behaviour:
- Reset (synchronous, arst high at clk edge): state=IDLE; ack=0; grant=0; tx_dv=0; tx_data=0; busy=0; err=0; lock=0; rr_ptr=NUM_REQ-1, so requester 0 wins the first arbitration.
- FSM states: IDLE, LOAD, WAIT.
- IDLE:
  - If any req is high, pick the first set bit scanning from rr_ptr+1 modulo NUM_REQ.
  - Register grant one-hot, set rr_ptr to the winner, go to LOAD.
  - No req: stay in IDLE.
- LOAD (exactly one cycle):
  - If the granted req is still high: tx_dv=1, tx_data=granted slice, ack[granted]=1; latch lock = ~req_last[granted]; go to WAIT.
  - If the granted req has dropped: no tx_dv or ack; grant clears next cycle; lock=0; go to IDLE.
- WAIT:
  - Hold grant and tx_data; ignore req changes.
  - On tx_done with lock=1 and the granted req high: go to LOAD with the same grant (no re-arbitration).
  - On tx_done with lock=0, or the granted req low: clear grant and lock, go to IDLE.
- Latency:
  - req rise in IDLE → grant at edge+1 → tx_dv/ack at edge+2.
  - Locked burst: tx_done → next tx_dv 2 cycles later.
  - Unlocked: tx_done → next grant 2 cycles later.
- tx_done outside WAIT is ignored (no state change).
- ack is never asserted for a non-granted requester; at most one ack bit per cycle.
- tx_dv and ack are always coincident.
- Simultaneous requests: strict round-robin. After requester k is served, k has lowest priority in the next arbitration.
- A requester that keeps req high with lock=0 is re-queued behind other pending requesters.
- Reset mid-frame: the FSM abandons the transfer with no ack. uart_tx shares the same reset, so no stale tx_done is expected.

Optional Feature:
- Macro UART_TX_ARBITER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT and clears on entry.
  - If it reaches TIMEOUT_CYCLES-1 without tx_done: err=1 for one cycle, grant and lock clear, state goes to IDLE, rr_ptr is kept.
  - A late tx_done after the abort is ignored.
- Undefined: no counter is built, err is tied 0, and WAIT waits indefinitely.

Test Plan:
- Single request: req=4'b0001, data0=8'hA5, req_last=1 → grant=0001 at edge+1; tx_dv=1, tx_data=8'hA5, ack=0001 at edge+2; after tx_done, grant=0 and busy=0 two cycles later.
- All four requesting, each req_last=1, model returns tx_done 20 cycles after tx_dv → serve order 0,1,2,3,0; exactly one ack per byte; tx_dv count matches ack count.
- Burst lock: requester 2 sends 3 bytes (8'h10,8'h11,8'h12, req_last=0,0,1) while requester 1 requests continuously → bytes 10,11,12 contiguous on tx_data; requester 1 is granted only after 8'h12's tx_done.
- Withdraw: requester 3 pulses req for 1 cycle while idle → grant=1000 for one cycle, no tx_dv, no ack, return to IDLE.
- Reset mid-WAIT: assert arst 5 cycles after tx_dv → next cycle all outputs 0; first post-reset arbitration with req=4'b1111 grants requester 0.
- With UART_TX_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, tx_done never sent → err pulses 16 cycles after WAIT entry, grant clears; a subsequent tx_done is ignored.
